// File: rtl/mac_sched.sv
// Job sequencer for the neuron MAC unit: walks every (layer, sample, neuron) triple,
// issues one MAC job per triple and writes each 64-bit result to the layer output buffer.
//
// Handshakes: mac_start is a one-cycle strobe; the job completes on the first cycle
// mac_done is high while waiting. A buffer write completes on a cycle with wr_en=1 and
// wr_ready=1; wr_en, wr_addr and wr_data stay stable until that cycle.
module mac_sched #(
    parameter int IDX_W   = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  cfg_samples,
    input  logic [IDX_W-1:0]  cfg_neurons,
    input  logic [IDX_W-1:0]  cfg_layers,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mac_start,
    output logic [IDX_W-1:0]  mac_sample,
    output logic [IDX_W-1:0]  mac_neuron,
    output logic [IDX_W-1:0]  mac_layer,
    input  logic              mac_done,
    input  logic [63:0]       mac_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    input  logic              wr_ready,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    logic [IDX_W-1:0]  n_samples;
    logic [IDX_W-1:0]  n_neurons;
    logic [IDX_W-1:0]  n_layers;
    logic [TW-1:0]     tcnt;
    logic [ADDR_W-1:0] lin_addr;

    // Linear buffer address; the product wraps modulo 2^ADDR_W by design.
    assign lin_addr  = ADDR_W'(mac_sample * n_neurons + mac_neuron);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_samples  <= '0;
            n_neurons  <= '0;
            n_layers   <= '0;
            tcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mac_start  <= 1'b0;
            mac_sample <= '0;
            mac_neuron <= '0;
            mac_layer  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_samples  <= cfg_samples;
                        n_neurons  <= cfg_neurons;
                        n_layers   <= cfg_layers;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        tcnt       <= '0;
                        mac_sample <= '0;
                        mac_neuron <= '0;
                        mac_layer  <= '0;
                        if (cfg_samples == '0 || cfg_neurons == '0 || cfg_layers == '0) begin
                            state <= S_FIN;
                        end else begin
                            mac_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    mac_start <= 1'b0;
                    tcnt      <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    // A result arriving on the last allowed cycle still wins over the timeout.
                    if (mac_done) begin
                        wr_data <= mac_result;
                        wr_addr <= lin_addr;
                        wr_en   <= 1'b1;
                        state   <= S_WRITE;
                    end else if (tcnt == T_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (mac_neuron == n_neurons - ONE) begin
                        mac_neuron <= '0;
                        if (mac_sample == n_samples - ONE) begin
                            mac_sample <= '0;
                            if (mac_layer == n_layers - ONE) begin
                                mac_layer <= '0;
                                state     <= S_FIN;
                            end else begin
                                mac_layer <= mac_layer + ONE;
                                mac_start <= 1'b1;
                                state     <= S_ISSUE;
                            end
                        end else begin
                            mac_sample <= mac_sample + ONE;
                            mac_start  <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end else begin
                        mac_neuron <= mac_neuron + ONE;
                        mac_start  <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_ERR: begin
                    mac_start <= 1'b0;
                    wr_en     <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Randomized bench for mac_sched: a behavioural MAC/buffer responder plus a job and
// write scoreboard derived from the nested (layer, sample, neuron) loop order.
module tb_mac_sched;
    localparam int IDX_W   = 32;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 64;
    localparam int JW      = 3 * IDX_W;
    localparam int WW      = ADDR_W + 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W-1:0]  cfg_samples = '0;
    logic [IDX_W-1:0]  cfg_neurons = '0;
    logic [IDX_W-1:0]  cfg_layers = '0;
    logic              busy, done, err, mac_start, wr_en;
    logic [IDX_W-1:0]  mac_sample, mac_neuron, mac_layer;
    logic              mac_done = 1'b0;
    logic [63:0]       mac_result = '0;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic              wr_ready = 1'b1;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    mac_sched #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_samples(cfg_samples), .cfg_neurons(cfg_neurons), .cfg_layers(cfg_layers),
        .busy(busy), .done(done), .err(err),
        .mac_start(mac_start), .mac_sample(mac_sample), .mac_neuron(mac_neuron),
        .mac_layer(mac_layer), .mac_done(mac_done), .mac_result(mac_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected jobs {sample, neuron, layer} and writes {addr, data}
    logic [JW-1:0] exp_job_q[$];
    logic [WW-1:0] exp_wr_q[$];

    int cyc = 0;
    int pend = 0;
    int mac_delay = 2;
    int stall_left = 0;
    bit rand_ready = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [JW-1:0]     cur_job = '0;
    logic [IDX_W-1:0]  run_neurons = '0;
    int n_start, n_wr, n_done, done_cyc, err_cyc, run_start_cyc, mac_start_cyc;
    logic err_prev = 1'b0;
    logic busy_prev = 1'b0;

    task automatic plan(input int s, input int n, input int l);
        for (int j = 0; j < l; j++)
            for (int i = 0; i < s; i++)
                for (int k = 0; k < n; k++)
                    exp_job_q.push_back({IDX_W'(i), IDX_W'(k), IDX_W'(j)});
    endtask

    // One clock: observe this cycle's outputs, then drive this cycle's responses.
    task automatic tick();
        logic [JW-1:0]    job;
        logic [WW-1:0]    wr;
        logic [63:0]      d;
        logic [IDX_W-1:0] js, jn, jl;
        @(posedge clk);
        #1;
        cyc++;
        mac_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                d = {$urandom, $urandom};
                mac_done = 1'b1;
                mac_result = d;
                exp_wr_q.push_back({pend_addr, d});
            end
        end
        if (mac_start) begin
            n_start++;
            mac_start_cyc = cyc;
            if (exp_job_q.size() == 0) begin
                check("unexpected_mac_start", 64'd1, 64'd0);
            end else begin
                job = exp_job_q.pop_front();
                cur_job = job;
                js = job[JW-1 -: IDX_W];
                jn = job[2*IDX_W-1 -: IDX_W];
                jl = job[IDX_W-1:0];
                check("mac_sample", 64'(mac_sample), 64'(js));
                check("mac_neuron", 64'(mac_neuron), 64'(jn));
                check("mac_layer", 64'(mac_layer), 64'(jl));
                pend_addr = ADDR_W'(js * run_neurons + jn);
                if (mac_delay > 0) pend = mac_delay;
            end
        end
        if (wr_en && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
            if (exp_wr_q.size() == 0) begin
                check("stall_no_expected_write", 64'd1, 64'd0);
            end else begin
                wr = exp_wr_q[0];
                check("stall_addr", 64'(wr_addr), 64'(wr[WW-1:64]));
                check("stall_data", wr_data, wr[63:0]);
            end
        end else begin
            wr_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
        if (wr_en && wr_ready) begin
            n_wr++;
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                wr = exp_wr_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(wr[WW-1:64]));
                check("wr_data", wr_data, wr[63:0]);
                check("idx_hold", 64'({mac_sample, mac_neuron, mac_layer} == cur_job), 64'd1);
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            check("busy_at_done", 64'(busy), 64'd0);
            check("busy_before_done", 64'(busy_prev), 64'd1);
        end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
        busy_prev = busy;
    endtask

    task automatic run(input int s, input int n, input int l, input int budget, input int inject_at);
        int t;
        plan(s, n, l);
        run_neurons = IDX_W'(n);
        n_start = 0; n_wr = 0; n_done = 0; done_cyc = -1; err_cyc = -1; mac_start_cyc = -1;
        cfg_samples = IDX_W'(s);
        cfg_neurons = IDX_W'(n);
        cfg_layers  = IDX_W'(l);
        start = 1'b1;
        run_start_cyc = cyc;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared_by_start", 64'(err), 64'd0);
        t = 0;
        while (!done && !err && t < budget) begin
            if (t == inject_at) begin
                start = 1'b1;
                cfg_samples = 3; cfg_neurons = 3; cfg_layers = 3;
            end
            tick();
            start = 1'b0;
            t++;
        end
        if (t >= budget) check("run_cycle_budget", 64'd0, 64'd1);
        repeat (3) tick();
    endtask

    task automatic expect_ok(input int jobs);
        check("n_mac_start", 64'(n_start), 64'(jobs));
        check("n_writes", 64'(n_wr), 64'(jobs));
        check("n_done", 64'(n_done), 64'd1);
        check("err_after_run", 64'(err), 64'd0);
        check("jobs_left", 64'(exp_job_q.size()), 64'd0);
        check("writes_left", 64'(exp_wr_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_mac_start"}, 64'(mac_start), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_idx"}, 64'({mac_sample, mac_neuron} | 64'(mac_layer)), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, wr_data, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic 2 samples x 3 neurons x 1 layer, fixed latency
        mac_delay = 2;
        run(2, 3, 1, 200, -1);
        expect_ok(6);

        // Zero neurons: no jobs, done two cycles after start
        run(2, 0, 1, 50, -1);
        expect_ok(0);
        check("zero_cfg_done_latency", 64'(done_cyc - run_start_cyc), 64'd2);

        // Write back-pressure on the first write
        stall_left = 5;
        run(2, 3, 1, 300, -1);
        expect_ok(6);
        check("stall_consumed", 64'(stall_left), 64'd0);

        // MAC never answers: timeout error
        mac_delay = 0;
        run(1, 1, 1, 300, -1);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_latency", 64'(err_cyc - mac_start_cyc), 64'(TIMEOUT + 1));
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_no_done", 64'(n_done), 64'd0);
        check("timeout_no_write", 64'(n_wr), 64'd0);
        exp_job_q.delete();
        exp_wr_q.delete();

        // Next start clears err and runs normally
        mac_delay = 2;
        run(1, 1, 1, 100, -1);
        expect_ok(1);

        // Two layers, with an ignored start pulse mid-run
        run(1, 1, 2, 200, 3);
        expect_ok(2);

        // Reset while waiting for a result; the late mac_done must be ignored
        mac_delay = 10;
        plan(1, 1, 2);
        run_neurons = 1;
        cfg_samples = 1; cfg_neurons = 1; cfg_layers = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midrun_reset");
        exp_job_q.delete();
        n_wr = 0; n_start = 0; n_done = 0;
        repeat (15) tick();
        check("late_done_no_write", 64'(n_wr), 64'd0);
        check("late_done_no_start", 64'(n_start), 64'd0);
        check("late_done_idle", 64'(busy), 64'd0);
        check("late_done_no_done", 64'(n_done), 64'd0);
        exp_wr_q.delete();

        // Result on the final cycle before timeout is still accepted
        mac_delay = TIMEOUT;
        run(1, 1, 1, 300, -1);
        expect_ok(1);

        // Random configurations, latencies and buffer back-pressure
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int s, n, l;
            s = $urandom_range(1, 3);
            n = $urandom_range(1, 3);
            l = $urandom_range(1, 3);
            mac_delay = $urandom_range(1, 6);
            run(s, n, l, 3000, -1);
            expect_ok(s * n * l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
